// File: rtl/hc_pkg.sv
// Shared constants and types for the hash-cracker candidate path.
// Consumed by idx_odometer and candidate_enumerator.
package hc_pkg;
  localparam int MAX_LEN = 8;
  localparam int CW      = 7;
  localparam int OW      = 6;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int PW      = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    ADVANCE,
    FINISH
  } enum_state_t;

  typedef logic [MAX_LEN-1:0][CW-1:0] cand_t;
  typedef logic [MAX_LEN-1:0][OW-1:0] idx_arr_t;

  // A run that can produce no candidate goes straight to FINISH.
  function automatic logic run_is_empty(input logic [OW-1:0] cs_len_i,
                                        input logic [LW-1:0] min_len_i,
                                        input logic [LW-1:0] max_len_i);
    return (cs_len_i == '0) || (min_len_i == '0) || (min_len_i > max_len_i) ||
           (max_len_i > LW'(MAX_LEN));
  endfunction
endpackage

// File: rtl/idx_odometer.sv
// Mixed-position odometer over MAX_LEN digits; digit 0 is least significant.
// Only the low cur_len digits count; carry_out flags a wrap of all of them.
module idx_odometer
  import hc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           inc,
  input  logic [OW-1:0]  radix,
  input  logic [LW-1:0]  cur_len,
  output idx_arr_t       idx,
  output logic           carry_out
);

  idx_arr_t idx_q;
  idx_arr_t idx_d;
  logic     carry;

  always_comb begin
    idx_d = idx_q;
    carry = 1'b0;
    if (clear) begin
      idx_d = '0;
    end else begin
      carry = inc;
      for (int k = 0; k < MAX_LEN; k++) begin
        if (carry && (k < int'(cur_len))) begin
          if (idx_q[k] == radix - OW'(1)) begin
            idx_d[k] = '0;
          end else begin
            idx_d[k] = idx_q[k] + OW'(1);
            carry    = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign idx       = idx_q;
  assign carry_out = carry;

endmodule

// File: rtl/candidate_enumerator.sv
// Walks every string over the loaded charset for lengths min_len..max_len and
// streams each candidate out. Optional CAND_COUNT_EN adds an accepted-candidate counter.
// Stream: a candidate transfers on a cycle where cand_valid && cand_ready; while
// cand_valid is high without cand_ready, cand_data/cand_len do not change.
module candidate_enumerator
  import hc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [OW-1:0]         cs_len,
  input  logic [LW-1:0]         min_len,
  input  logic [LW-1:0]         max_len,
  output logic [OW-1:0]         cs_ord,
  input  logic [CW-1:0]         cs_char,
  output logic                  cand_valid,
  input  logic                  cand_ready,
  output logic [MAX_LEN*CW-1:0] cand_data,
  output logic [LW-1:0]         cand_len,
  output logic                  busy,
  output logic                  done,
  output enum_state_t           dbg_state
`ifdef CAND_COUNT_EN
  ,
  output logic [47:0]           cand_count
`endif
);

  enum_state_t       state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [LW-1:0]     cur_len_q, cur_len_d;
  logic [LW-1:0]     max_len_q, max_len_d;
  logic [OW-1:0]     cs_len_q, cs_len_d;
  cand_t             buf_q, buf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              odo_clear;
  logic              odo_inc;
  idx_arr_t          odo_idx;
  logic              odo_carry;
  logic              fetch_last;

  idx_odometer u_odo (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (odo_clear),
    .inc       (odo_inc),
    .radix     (cs_len_q),
    .cur_len   (cur_len_q),
    .idx       (odo_idx),
    .carry_out (odo_carry)
  );

  assign fetch_last = (LW'(pos_q) == cur_len_q - LW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      cur_len_q <= '0;
      max_len_q <= '0;
      cs_len_q  <= '0;
      buf_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cur_len_q <= cur_len_d;
      max_len_q <= max_len_d;
      cs_len_q  <= cs_len_d;
      buf_q     <= buf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cur_len_d = cur_len_q;
    max_len_d = max_len_q;
    cs_len_d  = cs_len_q;
    buf_d     = buf_q;
    busy_d    = busy_q;
    done_d    = (state_q == FINISH);
    odo_clear = 1'b0;
    odo_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cs_len_d  = cs_len;
          max_len_d = max_len;
          cur_len_d = min_len;
          pos_d     = '0;
          buf_d     = '0;
          busy_d    = 1'b1;
          odo_clear = 1'b1;
          state_d   = run_is_empty(cs_len, min_len, max_len) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        buf_d[pos_q] = cs_char;
        if (fetch_last) begin
          pos_d   = '0;
          state_d = PRESENT;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end
      PRESENT: begin
        if (cand_ready) state_d = ADVANCE;
      end
      ADVANCE: begin
        odo_inc = 1'b1;
        state_d = FETCH;
        // Wrapping every live digit means all strings of this length are done.
        if (odo_carry) begin
          cur_len_d = cur_len_q + LW'(1);
          buf_d     = '0;
          if (cur_len_q + LW'(1) > max_len_q) state_d = FINISH;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cand_valid = (state_q == PRESENT);
    cs_ord     = (state_q == FETCH) ? odo_idx[pos_q] : '0;
    cand_data  = buf_q;
    cand_len   = cur_len_q;
    busy       = busy_q;
    done       = done_q;
    dbg_state  = state_q;
  end

`ifdef CAND_COUNT_EN
  logic [47:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q == IDLE) && start)               count_d = '0;
    else if ((state_q == PRESENT) && cand_ready)  count_d = count_q + 48'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign cand_count = count_q;
`endif

endmodule

// File: tb/tb_candidate_enumerator.sv
// Bench for candidate_enumerator: table of runs checked through a candidate
// scoreboard, plus hand-written reset and backpressure sequences.
module tb_candidate_enumerator;
  import hc_pkg::*;

  localparam int EW = LW + MAX_LEN * CW;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [OW-1:0]         cs_len = '0;
  logic [LW-1:0]         min_len = '0;
  logic [LW-1:0]         max_len = '0;
  logic [OW-1:0]         cs_ord;
  logic [CW-1:0]         cs_char;
  logic                  cand_valid;
  logic                  cand_ready = 1'b0;
  logic [MAX_LEN*CW-1:0] cand_data;
  logic [LW-1:0]         cand_len;
  logic                  busy;
  logic                  done;
  enum_state_t           dbg_state;
`ifdef CAND_COUNT_EN
  logic [47:0]           cand_count;
`endif

  logic [CW-1:0]   cs_mem [64];
  logic [EW-1:0]   exp_q [$];
  logic [EW-1:0]   held;
  logic            hold_pend = 1'b0;
  int              checks = 0;
  int              errors = 0;
  int              hs_count = 0;

  typedef struct {
    string cs;
    int    cs_len;
    int    mn;
    int    mx;
    int    exp_n;
    int    mode;        // 0 ready high, 1 random ready, 2 stall 4th candidate
    int    restart_at;  // edge at which a spurious start is pulsed, -1 none
  } vec_t;

  vec_t vecs [9];

  assign cs_char = cs_mem[cs_ord];

  candidate_enumerator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cs_len     (cs_len),
    .min_len    (min_len),
    .max_len    (max_len),
    .cs_ord     (cs_ord),
    .cs_char    (cs_char),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_data  (cand_data),
    .cand_len   (cand_len),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
`ifdef CAND_COUNT_EN
    ,
    .cand_count (cand_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference enumeration: candidate c of length L has digit k = (c / n**k) % n.
  function automatic void build_exp(input string s, input int n, input int mn, input int mx);
    logic [MAX_LEN*CW-1:0] d;
    int rem;
    int total;
    byte b;
    if (n == 0 || mn == 0 || mn > mx || mx > MAX_LEN) return;
    for (int l = mn; l <= mx; l++) begin
      total = 1;
      for (int k = 0; k < l; k++) total = total * n;
      for (int c = 0; c < total; c++) begin
        d   = '0;
        rem = c;
        for (int k = 0; k < l; k++) begin
          b = s[rem % n];
          d[k*CW +: CW] = b[CW-1:0];
          rem = rem / n;
        end
        exp_q.push_back({LW'(l), d});
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(cand_valid), 64'd1);
        check("hold_data", 64'({cand_len, cand_data}), 64'(held));
      end
      hold_pend = 1'b0;
      if (cand_valid && !cand_ready) begin
        hold_pend = 1'b1;
        held      = {cand_len, cand_data};
      end
      if (cand_valid && cand_ready) begin
        hs_count++;
        if (exp_q.size() == 0) check("unexpected_cand", 64'({cand_len, cand_data}), 64'd0);
        else check("cand", 64'({cand_len, cand_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic load_cs(input string s);
    byte b;
    for (int i = 0; i < 64; i++) cs_mem[i] = '0;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      cs_mem[i] = b[CW-1:0];
    end
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    int first_v;
    int done_at;
    int stall;
    load_cs(v.cs);
    exp_q.delete();
    build_exp(v.cs, v.cs_len, v.mn, v.mx);
    hs_count = 0;
    first_v  = -1;
    done_at  = -1;
    stall    = 0;
    start      = 1'b1;
    cs_len     = OW'(v.cs_len);
    min_len    = LW'(v.mn);
    max_len    = LW'(v.mx);
    cand_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    check("busy_after_start", 64'(busy), 64'd1);
    while (done_at < 0 && edges < 2000) begin
      if (cand_valid && first_v < 0) first_v = edges;
      if (done) done_at = edges;
      start = (edges == v.restart_at);
      if (start) begin
        cs_len  = OW'(2);
        min_len = LW'(1);
        max_len = LW'(1);
      end
      case (v.mode)
        1:       cand_ready = 1'($urandom_range(0, 1));
        2: begin
          if (cand_valid && hs_count == 3 && stall < 5) begin
            cand_ready = 1'b0;
            stall++;
          end else begin
            cand_ready = 1'b1;
          end
        end
        default: cand_ready = 1'b1;
      endcase
      if (done_at < 0) begin
        @(posedge clk); #1;
        edges++;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(done_at >= 0), 64'd1);
    if (v.exp_n == 0) begin
      check("done_latency", 64'(done_at), 64'd2);
      check("no_valid", 64'(first_v), 64'(-1));
    end else begin
      check("first_valid_lat", 64'(first_v), 64'(v.mn + 1));
    end
    check("busy_at_done", 64'(busy), 64'd0);
    check("cand_total", 64'(hs_count), 64'(v.exp_n));
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef CAND_COUNT_EN
    check("cand_count", 64'(cand_count), 64'(v.exp_n));
`endif
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int waited;
    vecs[0] = '{"ab",   2, 1, 2,  6, 0, -1};
    vecs[1] = '{"ab",   2, 1, 2,  6, 2, -1};
    vecs[2] = '{"ab",   0, 1, 2,  0, 0, -1};
    vecs[3] = '{"ab",   2, 3, 2,  0, 0, -1};
    vecs[4] = '{"xyz",  3, 3, 3, 27, 0, -1};
    vecs[5] = '{"q",    1, 1, 4,  4, 0,  4};
    vecs[6] = '{"ab",   2, 0, 2,  0, 0, -1};
    vecs[7] = '{"abcd", 4, 1, 2, 20, 1, -1};
    vecs[8] = '{"ab",   2, 1, 9,  0, 0, -1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(cand_valid), 64'd0);
    check("rst_data", 64'(cand_data), 64'd0);
    check("rst_len", 64'(cand_len), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_ord", 64'(cs_ord), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset in FETCH of the second candidate.
    load_cs("ab");
    exp_q.delete();
    build_exp("ab", 2, 1, 2);
    hs_count   = 0;
    start      = 1'b1;
    cs_len     = OW'(2);
    min_len    = LW'(1);
    max_len    = LW'(2);
    cand_ready = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    waited = 0;
    while (!(hs_count >= 1 && dbg_state == FETCH) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("reach_fetch2", 64'(waited < 50), 64'd1);
    check("fetch2_ord", 64'(cs_ord), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(cand_valid), 64'd0);
    check("mid_rst_ord", 64'(cs_ord), 64'd0);
    check("mid_rst_data", 64'(cand_data), 64'd0);
    check("mid_rst_len", 64'(cand_len), 64'd0);
    check("mid_rst_busy_done", 64'({busy, done}), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_rst", 64'({busy, done, cand_valid}), 64'd0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
